// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch-predictor resolve controller:
// FSM states, 2-bit counter encodings, in-flight queue entry and counter update.
package bpred_pkg;

  localparam int BPRED_IDX_W = 6;
  localparam int BPRED_DEPTH = 4;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic [BPRED_IDX_W-1:0] idx;
    logic                   pred;
  } qentry_t;

  // Saturating 2-bit counter step: never wraps past ST or SNT.
  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'b01;
    else       return (ctr == SNT) ? SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bpred_resolve_ctrl_if.sv
// Fetch/resolve signal bundle for bpred_resolve_ctrl. BPRED_PERF_EN adds the
// perf_resolved/perf_mispred counter outputs.
interface bpred_resolve_ctrl_if;

  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_is_branch;
  logic        pred_taken;
  logic        q_full;
  logic        e_valid;
  logic        e_actual;
  logic        e_is_jump;
  logic        flush;
  logic        target_sel;
  logic        pred_correct;
  logic        err_underflow;
`ifdef BPRED_PERF_EN
  logic [31:0] perf_resolved;
  logic [31:0] perf_mispred;

  modport master (
    output f_valid, f_pc, f_is_branch, e_valid, e_actual, e_is_jump,
    input  pred_taken, q_full, flush, target_sel, pred_correct, err_underflow,
    input  perf_resolved, perf_mispred
  );

  modport slave (
    input  f_valid, f_pc, f_is_branch, e_valid, e_actual, e_is_jump,
    output pred_taken, q_full, flush, target_sel, pred_correct, err_underflow,
    output perf_resolved, perf_mispred
  );
`else
  modport master (
    output f_valid, f_pc, f_is_branch, e_valid, e_actual, e_is_jump,
    input  pred_taken, q_full, flush, target_sel, pred_correct, err_underflow
  );

  modport slave (
    input  f_valid, f_pc, f_is_branch, e_valid, e_actual, e_is_jump,
    output pred_taken, q_full, flush, target_sel, pred_correct, err_underflow
  );
`endif

endinterface

// File: rtl/bpred_inflight_fifo.sv
// In-flight branch queue: DEPTH entries, wrap-bit pointers, clear wins over push/pop.
module bpred_inflight_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q, wrPtr_d;
  logic [AW:0]  rdPtr_q, rdPtr_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (clear) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wrPtr_q[AW-1:0]] <= wdata;
  end

  // Equal low bits with differing wrap bits means the write side lapped the read side.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdata = mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/bpred_resolve_ctrl.sv
// Branch predictor sequencer: BHT lookup at fetch, in-order resolve/train at EX.
// Defining BPRED_PERF_EN adds resolved/mispredict counters.
module bpred_resolve_ctrl
  import bpred_pkg::*;
#(
  parameter int IDX_W = BPRED_IDX_W,
  parameter int DEPTH = BPRED_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  bpred_resolve_ctrl_if.slave bus
);

  localparam int BHT_N = 2**IDX_W;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] initIdx_q, initIdx_d;
  logic [1:0]       bht_q [BHT_N];
  logic [IDX_W-1:0] fIdx;
  qentry_t          pushEntry, headEntry;
  logic             fifoFull, fifoEmpty, pushEn, popEn, clearEn;
  logic             actualTaken, mispredict, predTaken, qFull;
  logic             flush_q, flush_d, predCorrect_q, predCorrect_d;
  logic             targetSel_q, targetSel_d, errUnderflow_q, errUnderflow_d;
  logic             unusedPcBits;

  assign fIdx         = bus.f_pc[IDX_W+1:2];
  assign unusedPcBits = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0]};
  assign actualTaken  = bus.e_actual | bus.e_is_jump;
  assign mispredict   = headEntry.pred != actualTaken;
  assign pushEntry    = '{idx: fIdx, pred: predTaken};

  bpred_inflight_fifo #(.W($bits(qentry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushEn),
    .pop   (popEn),
    .clear (clearEn),
    .wdata (pushEntry),
    .rdata (headEntry),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_comb begin
    state_d        = state_q;
    initIdx_d      = initIdx_q;
    pushEn         = 1'b0;
    popEn          = 1'b0;
    clearEn        = 1'b0;
    flush_d        = 1'b0;
    predCorrect_d  = 1'b0;
    targetSel_d    = targetSel_q;
    errUnderflow_d = errUnderflow_q;
    predTaken      = 1'b0;
    qFull          = 1'b1;
    case (state_q)
      INIT: begin
        initIdx_d = initIdx_q + 1'b1;
        if (&initIdx_q) state_d = RUN;
      end
      RUN: begin
        qFull     = fifoFull;
        predTaken = bus.f_is_branch & bht_q[fIdx][1];
        popEn     = bus.e_valid & !fifoEmpty;
        pushEn    = bus.f_valid & bus.f_is_branch & (!fifoFull | popEn);
        if (bus.e_valid && fifoEmpty) errUnderflow_d = 1'b1;
        // A mispredict squashes everything younger, including this cycle's push.
        if (popEn) begin
          predCorrect_d = !mispredict;
          if (mispredict) begin
            flush_d     = 1'b1;
            targetSel_d = headEntry.pred;
            clearEn     = 1'b1;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        qFull     = fifoFull;
        predTaken = bus.f_is_branch & bht_q[fIdx][1];
        state_d   = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= INIT;
      initIdx_q      <= '0;
      flush_q        <= 1'b0;
      predCorrect_q  <= 1'b0;
      targetSel_q    <= 1'b1;
      errUnderflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      initIdx_q      <= initIdx_d;
      flush_q        <= flush_d;
      predCorrect_q  <= predCorrect_d;
      targetSel_q    <= targetSel_d;
      errUnderflow_q <= errUnderflow_d;
    end
  end

  // Table has no reset; the INIT sweep seeds every counter to weakly not-taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        bht_q[initIdx_q] <= WNT;
      end else if (popEn && !bus.e_is_jump) begin
        bht_q[headEntry.idx] <= satUpdate(bht_q[headEntry.idx], actualTaken);
      end
    end
  end

  assign bus.pred_taken    = predTaken;
  assign bus.q_full        = qFull;
  assign bus.flush         = flush_q;
  assign bus.target_sel    = targetSel_q;
  assign bus.pred_correct  = predCorrect_q;
  assign bus.err_underflow = errUnderflow_q;

`ifdef BPRED_PERF_EN
  logic [31:0] perfResolved_q, perfMispred_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perfResolved_q <= '0;
      perfMispred_q  <= '0;
    end else begin
      if (popEn)               perfResolved_q <= perfResolved_q + 32'd1;
      if (popEn && mispredict) perfMispred_q  <= perfMispred_q + 32'd1;
    end
  end

  assign bus.perf_resolved = perfResolved_q;
  assign bus.perf_mispred  = perfMispred_q;
`endif

endmodule
